// File: rtl/uart_rx.sv
// 8-bit UART receiver with 2-flop synchronizer, mid-bit sampling and a one-deep output holding register.
// Optional even-parity bit after the data bits is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLOCK_FREQUENCY = 12_000_000,
  parameter int unsigned BAUD_RATE       = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  input  logic       i_rx_ack,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int unsigned CLOCKS_PER_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned CNT_W = (CLOCKS_PER_BAUD > 2) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [CNT_W-1:0] HALF_BAUD = CNT_W'(CLOCKS_PER_BAUD / 2);
  localparam logic [CNT_W-1:0] FULL_BAUD = CNT_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,S_PARITY = 3'd4
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_prev;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_start_edge;
  logic             w_sample;
  logic             w_last_bit;
  logic             w_byte_done;
  logic             w_frame_err;
  logic             w_par_err;

  // r_fill marks when r_rx_s reflects the real line; r_armed needs a genuine high before any start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_fill    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_fill    <= {r_fill[0], 1'b1};
      r_armed   <= r_armed | (r_fill[1] & r_rx_s);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_next = S_START;
      S_START: if (w_sample) w_state_next = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (w_sample && w_last_bit) w_state_next = S_PARITY;
      S_PARITY: if (w_sample) w_state_next = S_STOP;
`else
      S_DATA:  if (w_sample && w_last_bit) w_state_next = S_STOP;
`endif
      S_STOP:  if (w_sample) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start_edge = r_armed & r_rx_prev & ~r_rx_s;
    w_sample     = (r_state != S_IDLE) && (r_baud_cnt == '0);
    w_last_bit   = (r_bit_idx == 3'd7);
    w_byte_done  = (r_state == S_STOP) && w_sample && r_rx_s;
    w_frame_err  = (r_state == S_STOP) && w_sample && !r_rx_s;
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;

  always_ff @(posedge i_clk) begin
    if (i_rst)                                 r_par_bit <= 1'b0;
    else if ((r_state == S_PARITY) && w_sample) r_par_bit <= r_rx_s;
  end

  // even parity: data ones plus parity bit must be even
  assign w_par_err = ^{r_shift, r_par_bit};
`else
  assign w_par_err = 1'b0;
`endif

  // baud counter: half bit to centre of start bit, then full bit periods
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      if (r_state == S_IDLE)  r_baud_cnt <= w_start_edge ? HALF_BAUD : '0;
      else if (w_sample)      r_baud_cnt <= FULL_BAUD;
      else                    r_baud_cnt <= r_baud_cnt - CNT_W'(1);

      if (r_state == S_START) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == S_DATA) && w_sample) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // holding register: a completing byte wins over a same-cycle ack
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_data   <= 8'h00;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= w_frame_err;
      o_overrun   <= w_byte_done & o_rx_valid & ~i_rx_ack;
      if (w_byte_done) begin
        o_rx_data  <= r_shift;
        o_rx_valid <= 1'b1;
      end else if (o_rx_valid && i_rx_ack) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_parity_err <= 1'b0;
    else       o_parity_err <= w_byte_done & w_par_err;
  end
`else
  assign o_parity_err = w_par_err;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate; CLOCKS_PER_BAUD = CLOCK_FREQUENCY/BAUD_RATE (integer division, 104 at defaults).
REQ-003 SHALL have port i_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port i_uart_rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port i_rx_ack, input, 1, consumer accepts o_rx_data when high with o_rx_valid.
REQ-007 SHALL have port o_rx_data, output, 8, last received byte.
REQ-008 SHALL have port o_rx_valid, output, 1, o_rx_data holds an unconsumed byte.
REQ-009 SHALL have port o_frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port o_overrun, output, 1, one-cycle pulse: unconsumed byte overwritten.
REQ-011 SHALL have port o_parity_err, output, 1, one-cycle pulse: parity mismatch (constant 0 when parity compiled out).

Function
REQ-012 SHALL pass i_uart_rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (parity builds only), STOP.
REQ-014 IDLE: on rx_s falling edge (previous 1, current 0) SHALL enter START and load the baud counter with CLOCKS_PER_BAUD/2.
REQ-015 SHALL decrement the baud counter each cycle outside IDLE; a sample point occurs when it reaches 0, then it reloads with CLOCKS_PER_BAUD-1.
REQ-016 START sample: rx_s=1 SHALL return to IDLE with no output activity (glitch rejection); rx_s=0 SHALL enter DATA.
REQ-017 DATA SHALL shift in 8 samples LSB first, then enter PARITY or STOP.
REQ-018 STOP sample: rx_s=1 SHALL write the byte to o_rx_data and set o_rx_valid on the next edge; rx_s=0 SHALL pulse o_frame_err, discard the byte, leave o_rx_data/o_rx_valid unchanged; both SHALL return to IDLE.
REQ-019 o_rx_valid SHALL stay high until a cycle with o_rx_valid=1 and i_rx_ack=1, then clear on the next edge; o_rx_data SHALL stay stable while o_rx_valid=1 except per REQ-020.
REQ-020 Byte completion while o_rx_valid=1 and i_rx_ack=0: SHALL overwrite o_rx_data, keep o_rx_valid=1, pulse o_overrun.
REQ-021 Byte completion in the same cycle as an accepting i_rx_ack: SHALL load the new byte, keep o_rx_valid=1, no o_overrun.
REQ-022 Byte-complete latency SHALL be 1 cycle after the stop-bit sample point.
REQ-023 i_rx_ack while o_rx_valid=0 SHALL be ignored.

Reset
REQ-024 i_rst=1 SHALL force IDLE, baud counter 0, synchronizer flops 1, o_rx_data=8'h00, o_rx_valid=0, o_frame_err=0, o_overrun=0, o_parity_err=0; mid-frame reset SHALL abandon the frame with no output pulse.
REQ-025 After reset release, a frame SHALL be detected only after rx_s has been seen high (no false start from a low line at release).

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: SHALL expect one even-parity bit after DATA; PARITY samples it; mismatch pulses o_parity_err at byte completion, byte still delivered; frame length 11 bits.
REQ-027 UART_RX_PARITY_EN undefined: SHALL have no PARITY state, o_parity_err tied 0, frame length 10 bits.

Verification
REQ-028 Defaults, send 8'hA5 at 104 clk/bit, i_rx_ack=0 -> o_rx_data=8'hA5, o_rx_valid=1 ~52+9*104 cycles after start edge; 1 cycle later i_rx_ack=1 -> o_rx_valid=0.
REQ-029 30-cycle low glitch on idle line -> no o_rx_valid, no error pulses, state IDLE.
REQ-030 Send 8'h3C with stop bit low -> o_frame_err one-cycle pulse, o_rx_valid stays 0.
REQ-031 Send 8'h11 then 8'h22 without ack -> o_overrun pulse, o_rx_data=8'h22, o_rx_valid=1; repeat with ack at completion cycle -> no o_overrun.
REQ-032 Assert i_rst during bit 4 of 8'hFF, release, send 8'h5A -> only 8'h5A delivered.
REQ-033 UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> o_rx_data=8'h07, o_parity_err pulse; parity bit 1 -> no pulse.
